instruction_queue: RTL and testbench
====================================

# instruction_queue

Parametrised instruction queue that supersedes the single-word instruction register between the fetch stage and the decoder. It buffers up to `DEPTH` fetched instruction words in order and presents the oldest word, already split into opcode and operand fields, to the decoder. A valid/ready style handshake sits on both sides. A synchronous flush discards queued words after a branch or jump.

## Interface

- `INSTRUCTION_WIDTH`, 16, instruction word width in bits.
- `OPCODE_WIDTH`, 4, width of the opcode field, taken from the MSBs of the word; must be < `INSTRUCTION_WIDTH`.
- `DEPTH`, 4, number of entries; must be ≥ 1.
- `COUNT_WIDTH`, `$clog2(DEPTH+1)`, width of the occupancy count; derived, not overridden.

Ports:

- `clock`  in  1  single clock; all state updates on the rising edge.
- `iq_reset_n`  in  1  asynchronous, active-low reset.
- `iq_flush`  in  1  synchronous flush; empties the queue.
- `iq_in`  in  `INSTRUCTION_WIDTH`  word from fetch.
- `iq_wr`  in  1  write request from fetch.
- `iq_full`  out  1  queue full; fetch must not write unless `iq_rd` is high in the same cycle.
- `iq_rd`  in  1  decoder consumes the head word.
- `iq_valid`  out  1  head word present (count > 0).
- `iq_out`  out  `INSTRUCTION_WIDTH`  head word; 0 when empty.
- `iq_opcode`  out  `OPCODE_WIDTH`  `iq_out[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH]`.
- `iq_operand`  out  `INSTRUCTION_WIDTH-OPCODE_WIDTH`  remaining low bits of `iq_out`.
- `iq_count`  out  `COUNT_WIDTH`  current occupancy.
- `iq_overflow`  out  1  sticky flag, set by a dropped write.

## Operation

- The storage is a circular buffer with a write pointer, a read pointer and a count. Each pointer wraps from `DEPTH-1` to 0; `DEPTH` need not be a power of two.
- Write accepted = `iq_wr && (!iq_full || iq_rd)`. An accepted write stores `iq_in` at the write pointer and advances the write pointer.
- Read accepted = `iq_rd && iq_valid`. An accepted read advances the read pointer. A read when empty is ignored and raises no flag.
- Write and read in the same cycle:
  - When not empty, both are accepted and count is unchanged.
  - When full, the write is accepted because the read frees the slot.
  - When empty, only the write is accepted, and the word appears at the head next cycle.
- Rejected write (`iq_wr && iq_full && !iq_rd`): the word is dropped, storage is unchanged, and `iq_overflow` is set.
- `iq_flush` has priority over `iq_wr` and `iq_rd` in the same cycle. It zeroes both pointers and the count and clears `iq_overflow`. Entry contents need not be cleared.
- `iq_full` = (count == `DEPTH`); `iq_valid` = (count != 0).
- `iq_out` = storage[read pointer] when valid, otherwise 0. Opcode and operand are pure slices of `iq_out`.
- With `DEPTH` = 1 the block behaves as the legacy instruction register with a full/valid handshake.

## Timing

- Reset (async assert, sync release): pointers = 0, count = 0, `iq_overflow` = 0. Therefore `iq_valid` = 0, `iq_full` = 0, `iq_out`/`iq_opcode`/`iq_operand` = 0, `iq_count` = 0.
- Reset asserted mid-operation discards all queued words immediately, without waiting for a clock edge.
- Write-to-head latency is 1 cycle: a word accepted at edge N is on `iq_out` after edge N if the queue was empty.
- A read accepted at edge N presents the next word, or 0 if none remains, after edge N.
- `iq_full`, `iq_valid` and `iq_count` reflect the state after the last edge. They have no combinational path from `iq_wr` or `iq_rd`.
- `iq_out` depends only on registered state. There is no input-to-output combinational path.

## Structure

- Shared package `instruction_pkg`:
  - default `INSTRUCTION_WIDTH`, default `OPCODE_WIDTH`
  - an opcode field typedef
  - a function splitting a word into opcode and operand, reused by the decoder.
- One sub-module, `queue_pointer`: a parametrised wrapping counter with increment, synchronous clear and async active-low reset. It is instantiated twice, once as the read pointer and once as the write pointer.
- Count, flags and storage live in `instruction_queue`.

## Test plan

- Reset, then write 0x2CB2 → after one edge: `iq_valid` = 1, `iq_out` = 0x2CB2, `iq_opcode` = 0x2, `iq_operand` = 0xCB2, `iq_count` = 1.
- Write 0x2CB2, 0xF492, 0x0613, 0x110F (DEPTH = 4) → `iq_full` = 1, `iq_count` = 4. An extra write of 0xAAAA without read sets `iq_overflow`; reads then return the 4 words in order and 0xAAAA never appears.
- Full queue, write 0x1234 with `iq_rd` in the same cycle → `iq_count` stays 4, 0x1234 is read fifth, and `iq_overflow` stays 0. Continue writes past index 3 to check pointer wrap.
- Empty queue: `iq_rd` alone → no change, `iq_out` = 0. Then `iq_wr`+`iq_rd` together with 0xF492 → `iq_count` = 1, `iq_out` = 0xF492.
- Queue holding 3 words, `iq_flush`+`iq_wr`+`iq_rd` in one cycle → count = 0, `iq_out` = 0, `iq_overflow` cleared, the written word is discarded.
- Assert `iq_reset_n` low between clock edges with 2 words queued → outputs go to 0 immediately, before any edge. Repeat the first write scenario with `DEPTH` = 1 and `DEPTH` = 3.

Source files
------------

// File: rtl/instruction_pkg.sv
// Shared definitions for the instruction path: default word geometry,
// field types and the opcode/operand split used by the queue and decoder.
package instruction_pkg;

  localparam int DEFAULT_INSTRUCTION_WIDTH = 16;
  localparam int DEFAULT_OPCODE_WIDTH      = 4;
  localparam int DEFAULT_OPERAND_WIDTH     = DEFAULT_INSTRUCTION_WIDTH - DEFAULT_OPCODE_WIDTH;

  typedef logic [DEFAULT_OPCODE_WIDTH-1:0]      opcode_t;
  typedef logic [DEFAULT_OPERAND_WIDTH-1:0]     operand_t;
  typedef logic [DEFAULT_INSTRUCTION_WIDTH-1:0] instruction_t;

  typedef struct packed {
    opcode_t  opcode;
    operand_t operand;
  } split_instruction_t;

  // Opcode lives in the MSBs, the operand is everything below it.
  function automatic split_instruction_t split_word(input instruction_t word);
    split_instruction_t result;
    result.opcode  = word[DEFAULT_INSTRUCTION_WIDTH-1 -: DEFAULT_OPCODE_WIDTH];
    result.operand = word[DEFAULT_OPERAND_WIDTH-1:0];
    return result;
  endfunction

endpackage

// File: rtl/queue_pointer.sv
// Wrapping index counter for a circular buffer of DEPTH entries. DEPTH does
// not have to be a power of two, so the wrap is an explicit compare.
module queue_pointer #(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 incr,
  output logic [PTR_WIDTH-1:0] ptr
);

  logic [PTR_WIDTH-1:0] ptr_q;
  logic [PTR_WIDTH-1:0] ptr_d;

  // Next index: clear wins, otherwise step and wrap from DEPTH-1 back to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (incr) begin
      if (ptr_q == PTR_WIDTH'(DEPTH - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + PTR_WIDTH'(1);
      end
    end
  end

  // Index register, async active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/instruction_queue.sv
// In-order instruction buffer between fetch and decode. Holds up to DEPTH
// words, presents the oldest one split into opcode/operand, and can be
// flushed in one cycle after a taken branch or jump.
module instruction_queue
  import instruction_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH,
  parameter int OPCODE_WIDTH      = DEFAULT_OPCODE_WIDTH,
  parameter int DEPTH             = 4
) (
  input  logic                                  clock,
  input  logic                                  iq_reset_n,
  input  logic                                  iq_flush,
  input  logic [INSTRUCTION_WIDTH-1:0]          iq_in,
  input  logic                                  iq_wr,
  output logic                                  iq_full,
  input  logic                                  iq_rd,
  output logic                                  iq_valid,
  output logic [INSTRUCTION_WIDTH-1:0]          iq_out,
  output logic [OPCODE_WIDTH-1:0]               iq_opcode,
  output logic [INSTRUCTION_WIDTH-OPCODE_WIDTH-1:0] iq_operand,
  output logic [$clog2(DEPTH+1)-1:0]            iq_count,
  output logic                                  iq_overflow
);

  localparam int COUNT_WIDTH = $clog2(DEPTH + 1);
  localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [INSTRUCTION_WIDTH-1:0] storage_q [DEPTH];
  logic [INSTRUCTION_WIDTH-1:0] storage_d [DEPTH];
  logic [COUNT_WIDTH-1:0]       count_q;
  logic [COUNT_WIDTH-1:0]       count_d;
  logic                         overflow_q;
  logic                         overflow_d;

  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic                 full;
  logic                 valid;
  logic                 wr_accept;
  logic                 rd_accept;
  logic                 wr_drop;

  // Flags come from the registered count only, never from wr/rd.
  always_comb begin
    full      = (count_q == COUNT_WIDTH'(DEPTH));
    valid     = (count_q != '0);
    // A read in the same cycle frees the slot a full queue would otherwise refuse.
    wr_accept = iq_wr && (!full || iq_rd) && !iq_flush;
    rd_accept = iq_rd && valid && !iq_flush;
    wr_drop   = iq_wr && full && !iq_rd && !iq_flush;
  end

  queue_pointer #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_rd_ptr (
    .clock   (clock),
    .reset_n (iq_reset_n),
    .clear   (iq_flush),
    .incr    (rd_accept),
    .ptr     (rd_ptr)
  );

  queue_pointer #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_wr_ptr (
    .clock   (clock),
    .reset_n (iq_reset_n),
    .clear   (iq_flush),
    .incr    (wr_accept),
    .ptr     (wr_ptr)
  );

  // Next count, overflow flag and storage contents; flush empties the queue.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    for (int i = 0; i < DEPTH; i++) begin
      storage_d[i] = storage_q[i];
    end
    if (iq_flush) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      count_d = count_q + COUNT_WIDTH'(wr_accept) - COUNT_WIDTH'(rd_accept);
      if (wr_drop) begin
        overflow_d = 1'b1;
      end
      if (wr_accept) begin
        storage_d[wr_ptr] = iq_in;
      end
    end
  end

  // State registers, async active-low reset.
  always_ff @(posedge clock or negedge iq_reset_n) begin
    if (!iq_reset_n) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        storage_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        storage_q[i] <= storage_d[i];
      end
    end
  end

  // Head word is forced to zero when empty so stale entries never leak out.
  always_comb begin
    iq_out = valid ? storage_q[rd_ptr] : '0;
  end

  assign iq_full     = full;
  assign iq_valid    = valid;
  assign iq_count    = count_q;
  assign iq_overflow = overflow_q;
  assign iq_opcode   = iq_out[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  assign iq_operand  = iq_out[INSTRUCTION_WIDTH-OPCODE_WIDTH-1:0];

endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: three instances (DEPTH 4, 1, 3) share one
// stimulus stream and are each checked every cycle against a queue model.
module tb_instruction_queue;
  import instruction_pkg::*;

  logic        clock = 1'b0;
  logic        iq_reset_n;
  logic        iq_flush;
  logic        iq_wr;
  logic        iq_rd;
  logic [15:0] iq_in;

  logic [15:0] out_w   [3];
  logic [3:0]  opc_w   [3];
  logic [11:0] opr_w   [3];
  logic [2:0]  cnt_w   [3];
  logic        valid_w [3];
  logic        full_w  [3];
  logic        ovf_w   [3];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  function automatic int dep_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D  = (g == 0) ? 4 : ((g == 1) ? 1 : 3);
    localparam int CW = $clog2(D + 1);
    logic [CW-1:0] cnt_l;
    instruction_queue #(
      .INSTRUCTION_WIDTH (16),
      .OPCODE_WIDTH      (4),
      .DEPTH             (D)
    ) dut (
      .clock       (clock),
      .iq_reset_n  (iq_reset_n),
      .iq_flush    (iq_flush),
      .iq_in       (iq_in),
      .iq_wr       (iq_wr),
      .iq_full     (full_w[g]),
      .iq_rd       (iq_rd),
      .iq_valid    (valid_w[g]),
      .iq_out      (out_w[g]),
      .iq_opcode   (opc_w[g]),
      .iq_operand  (opr_w[g]),
      .iq_count    (cnt_l),
      .iq_overflow (ovf_w[g])
    );
    assign cnt_w[g] = 3'(cnt_l);
  end

  // Reference model: an ordered list of words plus a sticky overflow bit.
  logic [15:0] mq   [3][$];
  logic        movf [3];

  always @(posedge clock or negedge iq_reset_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!iq_reset_n) begin
        mq[i].delete();
        movf[i] = 1'b0;
      end else if (iq_flush) begin
        mq[i].delete();
        movf[i] = 1'b0;
      end else begin
        automatic bit is_full  = (mq[i].size() == dep_of(i));
        automatic bit is_empty = (mq[i].size() == 0);
        automatic bit take_rd  = iq_rd && !is_empty;
        automatic bit take_wr  = iq_wr && (!is_full || iq_rd);
        if (iq_wr && is_full && !iq_rd) movf[i] = 1'b1;
        if (take_rd) void'(mq[i].pop_front());
        if (take_wr) mq[i].push_back(iq_in);
      end
    end
  end

  task automatic check_output(input string name, input int inst,
                              input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s inst%0d actual=%0h required=%0h", name, inst, act, exp);
    end
  endtask

  // Per-cycle compare on the falling edge, away from the state update.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      automatic logic [15:0] exp_out = (mq[i].size() != 0) ? mq[i][0] : 16'h0;
      automatic split_instruction_t sp = split_word(exp_out);
      check_output("out",      i, 32'(out_w[i]),   32'(exp_out));
      check_output("opcode",   i, 32'(opc_w[i]),   32'(sp.opcode));
      check_output("operand",  i, 32'(opr_w[i]),   32'(sp.operand));
      check_output("count",    i, 32'(cnt_w[i]),   32'(mq[i].size()));
      check_output("valid",    i, 32'(valid_w[i]), 32'(mq[i].size() != 0));
      check_output("full",     i, 32'(full_w[i]),  32'(mq[i].size() == dep_of(i)));
      check_output("overflow", i, 32'(ovf_w[i]),   32'(movf[i]));
    end
  end

  // Drive one cycle of inputs, return just after the following falling edge.
  task automatic apply_stimulus(input logic f, input logic w, input logic r,
                                input logic [15:0] din);
    iq_flush = f;
    iq_wr    = w;
    iq_rd    = r;
    iq_in    = din;
    @(posedge clock);
    @(negedge clock);
    #1;
    iq_flush = 1'b0;
    iq_wr    = 1'b0;
    iq_rd    = 1'b0;
  endtask

  initial begin
    logic [15:0] fill_words [4];
    logic [15:0] wrap_words [4];
    fill_words = '{16'h2CB2, 16'hF492, 16'h0613, 16'h110F};
    wrap_words = '{16'h2222, 16'h3333, 16'h4444, 16'h1234};

    iq_reset_n = 1'b0;
    iq_flush   = 1'b0;
    iq_wr      = 1'b0;
    iq_rd      = 1'b0;
    iq_in      = 16'h0;
    repeat (2) @(negedge clock);
    iq_reset_n = 1'b1;
    #1;
    check_output("rst_valid", 0, 32'(valid_w[0]), 32'h0);
    check_output("rst_count", 0, 32'(cnt_w[0]),   32'h0);

    // First write reaches the head one edge later, for every depth.
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h2CB2);
    for (int i = 0; i < 3; i++) begin
      check_output("w1_valid",   i, 32'(valid_w[i]), 32'h1);
      check_output("w1_out",     i, 32'(out_w[i]),   32'h2CB2);
      check_output("w1_opcode",  i, 32'(opc_w[i]),   32'h2);
      check_output("w1_operand", i, 32'(opr_w[i]),   32'hCB2);
      check_output("w1_count",   i, 32'(cnt_w[i]),   32'h1);
    end

    // Fill to four, then a dropped write.
    for (int k = 1; k < 4; k++) apply_stimulus(1'b0, 1'b1, 1'b0, fill_words[k]);
    check_output("fill_full",  0, 32'(full_w[0]), 32'h1);
    check_output("fill_count", 0, 32'(cnt_w[0]),  32'h4);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'hAAAA);
    check_output("drop_ovf",   0, 32'(ovf_w[0]),  32'h1);
    for (int k = 0; k < 4; k++) begin
      check_output("drain_out", 0, 32'(out_w[0]), 32'(fill_words[k]));
      apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0);
    end
    check_output("drain_empty", 0, 32'(out_w[0]), 32'h0);

    // Full queue with simultaneous read and write, then wrap.
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h1111);
    for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 1'b1, 1'b0, wrap_words[k]);
    apply_stimulus(1'b0, 1'b1, 1'b1, 16'h1234);
    check_output("rw_count", 0, 32'(cnt_w[0]), 32'h4);
    check_output("rw_ovf",   0, 32'(ovf_w[0]), 32'h0);
    for (int k = 0; k < 4; k++) begin
      check_output("wrap_out", 0, 32'(out_w[0]), 32'(wrap_words[k]));
      apply_stimulus(1'b0, 1'b1, 1'b1, 16'h5000 + 16'(k));
    end

    // Empty queue: lone read, then read+write together.
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0);
    check_output("erd_out",   0, 32'(out_w[0]), 32'h0);
    check_output("erd_count", 0, 32'(cnt_w[0]), 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 16'hF492);
    check_output("erw_count", 0, 32'(cnt_w[0]), 32'h1);
    check_output("erw_out",   0, 32'(out_w[0]), 32'hF492);

    // Three words queued, flush beats write and read.
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0613);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h110F);
    check_output("pre_fl_ovf1", 1, 32'(ovf_w[1]), 32'h1);
    apply_stimulus(1'b1, 1'b1, 1'b1, 16'h5555);
    check_output("fl_count", 0, 32'(cnt_w[0]), 32'h0);
    check_output("fl_out",   0, 32'(out_w[0]), 32'h0);
    check_output("fl_ovf1",  1, 32'(ovf_w[1]), 32'h0);

    // Reset between edges with two words queued.
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h7ABC);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h8DEF);
    #2;
    iq_reset_n = 1'b0;
    #1;
    check_output("arst_valid", 0, 32'(valid_w[0]), 32'h0);
    check_output("arst_out",   0, 32'(out_w[0]),   32'h0);
    check_output("arst_count", 0, 32'(cnt_w[0]),   32'h0);
    @(negedge clock);
    iq_reset_n = 1'b1;
    #1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      apply_stimulus(($urandom_range(0, 39) == 0),
                     ($urandom_range(0, 99) < 60),
                     ($urandom_range(0, 99) < 50),
                     16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
